// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-path definitions: FSM state encoding, reset/vector defaults,
// word-alignment mask and the redirect payload carried into the pending latch.
package fetch_sequencer_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_0040;
   localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } state_e;

   // Numeric order is the priority order: a larger code wins
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_BR   = 2'd1,
      RD_ERET = 2'd2,
      RD_EXC  = 2'd3
   } rd_kind_e;

   typedef struct packed {
      rd_kind_e        kind;
      logic [XLEN-1:0] target;
   } redirect_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & WORD_MASK;
   endfunction

   function automatic logic is_misaligned(input logic [XLEN-1:0] a);
      return (a & ~WORD_MASK) != '0;
   endfunction

endpackage

// File: rtl/fetch_sequencer_pending.sv
// Priority latch for a redirect that arrives while the ROM is still busy.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : drop the pending entry (it has been consumed)
//   load      : capture in_rd if it outranks the held entry
//   in_rd     : redirect presented this cycle (kind RD_NONE when idle)
//   merged_c  : higher-priority of {held entry, in_rd}, combinational
module fetch_sequencer_pending
   import fetch_sequencer_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      load,
   input  redirect_t in_rd,
   output redirect_t merged_c
);

   redirect_t pend_q;

   // Held entry; only a strictly higher-priority redirect overwrites it
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pend_q <= '0;
      end else if (load && (in_rd.kind > pend_q.kind)) begin
         pend_q <= in_rd;
      end
   end

   // Winner between what is held and what arrives this cycle
   always_comb begin
      merged_c = pend_q;
      if (in_rd.kind > pend_q.kind) begin
         merged_c = in_rd;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: owns the fetch PC and EPC, arbitrates exception entry,
// exception return, branch redirect, stall, ROM wait and sequential fetch.
//   clk, rst        : clock, synchronous active-high reset
//   stall_req       : hold PC (ID hazard)
//   br_taken/target : taken branch/jump and its target
//   exc_req/exc_pc  : exception request and faulting PC
//   eret            : return from exception
//   halt_req        : enter HALT
//   rom_ready       : ROM returns the instruction at pc this cycle
//   pc, rom_ce      : ROM fetch address and enable
//   if_valid        : instruction at pc is valid into IF/ID
//   flush_ifid      : kill IF/ID this cycle
//   epc             : saved exception PC
//   misalign        : taken branch target had nonzero bits [1:0]
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_req,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   input  logic        eret,
   input  logic        halt_req,
   input  logic        rom_ready,
   output logic [31:0] pc,
   output logic        rom_ce,
   output logic        if_valid,
   output logic        flush_ifid,
   output logic [31:0] epc,
   output logic        misalign
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;

   redirect_t   new_rd;
   redirect_t   merged_rd;
   logic        new_mis;
   logic        pend_load;
   logic        pend_clr;

   // Incoming redirect this cycle, already priority-resolved
   always_comb begin
      new_rd  = '0;
      new_mis = 1'b0;
      if (exc_req) begin
         new_rd.kind   = RD_EXC;
         new_rd.target = EXC_VEC;
      end else if (eret) begin
         new_rd.kind   = RD_ERET;
         new_rd.target = epc_q;
      end else if (br_taken) begin
         new_rd.kind   = RD_BR;
         new_rd.target = word_align(br_target);
         new_mis       = is_misaligned(br_target);
      end
   end

   fetch_sequencer_pending u_pending (
      .clk      (clk),
      .rst      (rst),
      .clr      (pend_clr),
      .load     (pend_load),
      .in_rd    (new_rd),
      .merged_c (merged_rd)
   );

   // State, PC and EPC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   // Next-state, next-PC and per-cycle fetch controls
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      rom_ce     = 1'b0;
      if_valid   = 1'b0;
      flush_ifid = 1'b0;
      misalign   = 1'b0;
      pend_load  = 1'b0;
      pend_clr   = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end

         FETCH: begin
            rom_ce = 1'b1;
            if (new_rd.kind != RD_NONE) begin
               pc_d       = new_rd.target;
               flush_ifid = 1'b1;
               misalign   = new_mis;
               if (exc_req) begin
                  epc_d = exc_pc;
               end
            end else if (halt_req) begin
               state_d = HALT;
            end else if (stall_req) begin
               pc_d = pc_q;
            end else if (!rom_ready) begin
               state_d = WAIT;
            end else begin
               pc_d     = pc_q + 32'd4;
               if_valid = 1'b1;
            end
         end

         WAIT: begin
            rom_ce = 1'b1;
            if (new_rd.kind != RD_NONE) begin
               flush_ifid = 1'b1;
               misalign   = new_mis;
               if (exc_req) begin
                  epc_d = exc_pc;
               end
            end
            if (rom_ready) begin
               state_d  = FETCH;
               pend_clr = 1'b1;
               if (merged_rd.kind != RD_NONE) begin
                  // Returned instruction is on the wrong path; drop it
                  pc_d = merged_rd.target;
               end else begin
                  pc_d     = pc_q + 32'd4;
                  if_valid = 1'b1;
               end
            end else begin
               pend_load = (new_rd.kind != RD_NONE);
            end
         end

         HALT: begin
            // Only an exception wakes the core; the halted pc is the return point
            if (exc_req) begin
               epc_d   = pc_q;
               pc_d    = EXC_VEC;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      if (rst) begin
         rom_ce     = 1'b0;
         if_valid   = 1'b0;
         flush_ifid = 1'b0;
         misalign   = 1'b0;
         pend_load  = 1'b0;
      end
   end

   assign pc  = pc_q;
   assign epc = epc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a vector table for the main flow
// plus hand-written WAIT/reset sequences, checked through a scoreboard queue.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        stall_req;
   logic        br_taken;
   logic [31:0] br_target;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic        eret;
   logic        halt_req;
   logic        rom_ready;
   logic [31:0] pc;
   logic        rom_ce;
   logic        if_valid;
   logic        flush_ifid;
   logic [31:0] epc;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst, stall, br, exc, eret, halt, ready;
      logic [31:0] bt, xpc;
      logic [31:0] e_pc;
      logic        e_ce, e_val, e_fl, e_mis;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   fetch_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .stall_req  (stall_req),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .exc_req    (exc_req),
      .exc_pc     (exc_pc),
      .eret       (eret),
      .halt_req   (halt_req),
      .rom_ready  (rom_ready),
      .pc         (pc),
      .rom_ce     (rom_ce),
      .if_valid   (if_valid),
      .flush_ifid (flush_ifid),
      .epc        (epc),
      .misalign   (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(input logic r, st, b, x, er, h, rdy,
                              input logic [31:0] bt, xp,
                              input logic [31:0] epc_v,
                              input logic ce, vl, fl, ms,
                              input logic [31:0] eepc);
      vec_t t;
      t.rst = r; t.stall = st; t.br = b; t.exc = x; t.eret = er; t.halt = h; t.ready = rdy;
      t.bt = bt; t.xpc = xp;
      t.e_pc = epc_v; t.e_ce = ce; t.e_val = vl; t.e_fl = fl; t.e_mis = ms; t.e_epc = eepc;
      return t;
   endfunction

   // Plain sequential fetch cycle with ROM ready
   function automatic vec_t s(input logic [31:0] p, input logic [31:0] e);
      return v(0,0,0,0,0,0,1, 32'h0, 32'h0, p, 1,1,0,0, e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after settle
   task automatic step(input vec_t t);
      vec_t e;
      @(negedge clk);
      rst = t.rst; stall_req = t.stall; br_taken = t.br; exc_req = t.exc;
      eret = t.eret; halt_req = t.halt; rom_ready = t.ready;
      br_target = t.bt; exc_pc = t.xpc;
      exp_q.push_back(t);
      #1;
      e = exp_q.pop_front();
      chk("pc",         pc,                e.e_pc);
      chk("rom_ce",     32'(rom_ce),       32'(e.e_ce));
      chk("if_valid",   32'(if_valid),     32'(e.e_val));
      chk("flush_ifid", 32'(flush_ifid),   32'(e.e_fl));
      chk("misalign",   32'(misalign),     32'(e.e_mis));
      chk("epc",        epc,               e.e_epc);
      if (if_valid && flush_ifid) begin
         total++;
         bad++;
         $display("FAIL valid_flush_overlap: if_valid=1 flush_ifid=1 expected not both");
      end
   endtask

   initial begin
      rst = 1'b1; stall_req = 1'b0; br_taken = 1'b0; br_target = '0;
      exc_req = 1'b0; exc_pc = '0; eret = 1'b0; halt_req = 1'b0; rom_ready = 1'b1;
      @(posedge clk);

      // reset held two more cycles, then BOOT and sequential fetch
      tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 32'h0, 0,0,0,0, 32'h0));
      tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 32'h0, 0,0,0,0, 32'h0));
      tbl.push_back(v(0,0,0,0,0,0,1, 0, 0, 32'h0, 0,0,0,0, 32'h0));
      tbl.push_back(s(32'h00, 0)); tbl.push_back(s(32'h04, 0));
      tbl.push_back(s(32'h08, 0)); tbl.push_back(s(32'h0C, 0));
      // misaligned branch at 0x10
      tbl.push_back(v(0,0,1,0,0,0,1, 32'h103, 0, 32'h10, 1,0,1,1, 32'h0));
      tbl.push_back(s(32'h100, 0)); tbl.push_back(s(32'h104, 0));
      tbl.push_back(v(0,0,1,0,0,0,1, 32'h18, 0, 32'h108, 1,0,1,0, 32'h0));
      tbl.push_back(s(32'h18, 0)); tbl.push_back(s(32'h1C, 0));
      // exception at 0x20, then eret
      tbl.push_back(v(0,0,0,1,0,0,1, 0, 32'h1C, 32'h20, 1,0,1,0, 32'h0));
      tbl.push_back(s(32'h40, 32'h1C));
      tbl.push_back(v(0,0,0,0,1,0,1, 0, 0, 32'h44, 1,0,1,0, 32'h1C));
      tbl.push_back(s(32'h1C, 32'h1C)); tbl.push_back(s(32'h20, 32'h1C));
      tbl.push_back(s(32'h24, 32'h1C)); tbl.push_back(s(32'h28, 32'h1C));
      tbl.push_back(s(32'h2C, 32'h1C));
      // ROM wait at 0x30 with branch in the second wait cycle
      tbl.push_back(v(0,0,0,0,0,0,0, 0, 0, 32'h30, 1,0,0,0, 32'h1C));
      tbl.push_back(v(0,0,1,0,0,0,0, 32'h200, 0, 32'h30, 1,0,1,0, 32'h1C));
      tbl.push_back(v(0,0,0,0,0,0,0, 0, 0, 32'h30, 1,0,0,0, 32'h1C));
      tbl.push_back(v(0,0,0,0,0,0,1, 0, 0, 32'h30, 1,0,0,0, 32'h1C));
      tbl.push_back(s(32'h200, 32'h1C));
      // stall + branch: branch wins; then stall alone twice
      tbl.push_back(v(0,1,1,0,0,0,1, 32'h300, 0, 32'h204, 1,0,1,0, 32'h1C));
      tbl.push_back(v(0,1,0,0,0,0,1, 0, 0, 32'h300, 1,0,0,0, 32'h1C));
      tbl.push_back(v(0,1,0,0,0,0,1, 0, 0, 32'h300, 1,0,0,0, 32'h1C));
      tbl.push_back(s(32'h300, 32'h1C)); tbl.push_back(s(32'h304, 32'h1C));
      tbl.push_back(v(0,0,1,0,0,0,1, 32'h50, 0, 32'h308, 1,0,1,0, 32'h1C));
      // halt at 0x50, ignored events, exception wake-up
      tbl.push_back(v(0,0,0,0,0,1,1, 0, 0, 32'h50, 1,0,0,0, 32'h1C));
      tbl.push_back(v(0,0,1,0,0,0,1, 32'h80, 0, 32'h50, 0,0,0,0, 32'h1C));
      tbl.push_back(v(0,1,0,0,1,0,1, 0, 0, 32'h50, 0,0,0,0, 32'h1C));
      tbl.push_back(v(0,0,0,1,0,0,1, 0, 32'h999, 32'h50, 0,0,0,0, 32'h1C));
      tbl.push_back(s(32'h40, 32'h50)); tbl.push_back(s(32'h44, 32'h50));
      // PC wrap at the top of the address space
      tbl.push_back(v(0,0,1,0,0,0,1, 32'hFFFF_FFF8, 0, 32'h48, 1,0,1,0, 32'h50));
      tbl.push_back(s(32'hFFFF_FFF8, 32'h50));
      tbl.push_back(s(32'hFFFF_FFFC, 32'h50));
      tbl.push_back(s(32'h0, 32'h50));

      foreach (tbl[i]) step(tbl[i]);

      // WAIT: branch pending, overwritten by exception, later branch ignored
      step(v(0,0,0,0,0,0,0, 0, 0, 32'h04, 1,0,0,0, 32'h50));
      step(v(0,0,1,0,0,0,0, 32'h400, 0, 32'h04, 1,0,1,0, 32'h50));
      step(v(0,0,0,1,0,0,0, 0, 32'h77, 32'h04, 1,0,1,0, 32'h50));
      step(v(0,0,1,0,0,0,0, 32'h500, 0, 32'h04, 1,0,1,0, 32'h77));
      step(v(0,0,0,0,0,0,1, 0, 0, 32'h04, 1,0,0,0, 32'h77));
      step(s(32'h40, 32'h77));

      // WAIT: redirect and rom_ready in the same cycle go straight to target
      step(v(0,0,0,0,0,0,0, 0, 0, 32'h44, 1,0,0,0, 32'h77));
      step(v(0,0,1,0,0,0,1, 32'h600, 0, 32'h44, 1,0,1,0, 32'h77));
      step(s(32'h600, 32'h77));

      // reset in the middle of WAIT
      step(v(0,0,0,0,0,0,0, 0, 0, 32'h604, 1,0,0,0, 32'h77));
      step(v(0,0,0,0,0,0,0, 0, 0, 32'h604, 1,0,0,0, 32'h77));
      step(v(1,0,0,0,0,0,0, 0, 0, 32'h604, 0,0,0,0, 32'h77));
      step(v(0,0,0,0,0,0,1, 0, 0, 32'h0, 0,0,0,0, 32'h0));
      step(s(32'h0, 32'h0));
      step(s(32'h4, 32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns and sequences the fetch program counter.
- Arbitrates competing PC sources by fixed priority: exception entry, exception return, branch/jump redirect, pipeline stall, instruction-memory wait, sequential +4.
- Sits between the ID/EX hazard and branch logic and the instruction ROM.
- Drives the ROM address and enable, the IF/ID valid and flush signals, and holds the EPC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- EXC_VEC, 32'h0000_0040, exception/interrupt entry address.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_req  in  1  load-use/structural stall from ID; hold PC.
- br_taken  in  1  branch/jump resolved taken this cycle.
- br_target  in  32  redirect target, valid with br_taken.
- exc_req  in  1  exception or interrupt request.
- exc_pc  in  32  PC of faulting instruction, valid with exc_req.
- eret  in  1  return from exception.
- halt_req  in  1  halt request (break/wait instruction).
- rom_ready  in  1  ROM returns instruction for current pc this cycle.
- pc  out  32  current fetch address to ROM.
- rom_ce  out  1  ROM enable.
- if_valid  out  1  instruction at pc is valid into IF/ID this cycle.
- flush_ifid  out  1  kill IF/ID contents this cycle.
- epc  out  32  saved exception PC.
- misalign  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- State machine states: BOOT, FETCH, WAIT, HALT.
- rst high: state<=BOOT, pc<=RESET_PC, epc<=0, pending redirect cleared.
  - All outputs 0 except pc=RESET_PC.
  - rst overrides everything, including mid-WAIT and HALT.
- BOOT: rom_ce=0, if_valid=0. Moves to FETCH the next cycle unconditionally.
- FETCH: rom_ce=1. Priority (highest first) for the next-PC decision:
  1. exc_req: epc<=exc_pc, pc<=EXC_VEC, flush_ifid=1.
  2. eret: pc<=epc, flush_ifid=1.
  3. br_taken: pc<={br_target[31:2],2'b00}, flush_ifid=1; misalign=1 same cycle if br_target[1:0]!=0.
  4. stall_req: pc holds, if_valid=0.
  5. !rom_ready: pc holds, if_valid=0, state<=WAIT.
  6. Otherwise: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), if_valid=1.
  7. halt_req (with no redirect active): pc holds, state<=HALT, if_valid=0.
- if_valid is never 1 in a cycle with flush_ifid=1.
- Redirect latency: a redirect asserted in cycle N is the fetch address in cycle N+1.
- WAIT: rom_ce=1, pc holds, if_valid=0.
  - On rom_ready: if no redirect is pending, pc<=pc+4, if_valid=1, state<=FETCH.
  - A redirect (exc_req/eret/br_taken) arriving in WAIT is latched into a pending register using the same priority (exc latches epc immediately); flush_ifid=1 that cycle.
  - Later redirects in WAIT overwrite only a lower-priority pending entry.
  - On rom_ready with a redirect pending: the returned instruction is discarded (if_valid=0), pc<=pending target, pending cleared, state<=FETCH.
  - Redirect and rom_ready in the same WAIT cycle: redirect wins directly, pc<=target.
- HALT: rom_ce=0, pc holds.
  - Only exc_req leaves HALT: epc<=pc, pc<=EXC_VEC, state<=FETCH.
  - eret, br_taken and stall_req are ignored in HALT.
- epc changes only on exception entry or rst.

Decomposition:
- Shared CPU package holds:
  - state encoding (2-bit: BOOT=0, FETCH=1, WAIT=2, HALT=3);
  - RESET_PC and EXC_VEC defaults;
  - the 32-bit word-alignment mask.
- One natural sub-module: redirect_pending, a priority latch holding the pending target plus a kind code (exc/eret/branch).
- The FSM and PC register stay in fetch_sequencer.

Test Plan:
- rst 3 cycles, then ready=1, no events -> BOOT 1 cycle with rom_ce=0, then pc 0,4,8,... with if_valid=1 each cycle.
- At pc=0x10: br_taken=1, target=0x103 -> misalign=1, flush_ifid=1, next pc=0x100, then 0x104.
- At pc=0x20: exc_req=1, exc_pc=0x1C -> epc=0x1C, next pc=0x40; later eret=1 -> next pc=0x1C.
- At pc=0x30: rom_ready=0 for 3 cycles, br_taken target 0x200 in 2nd wait cycle -> pc held 0x30, rom_ready returns with if_valid=0, next pc=0x200.
- In FETCH: stall_req and br_taken in the same cycle -> redirect wins, pc=target; stall_req alone 2 cycles -> pc unchanged, if_valid=0.
- halt_req at pc=0x50 -> HALT, rom_ce=0; br_taken ignored; exc_req -> epc=0x50, pc=0x40. rst asserted mid-WAIT -> pc=0, state BOOT.
